riscv_i32_fetch_debug_ctrl: RTL and testbench



---
 rtl/riscv_i32_fetch_debug_ctrl_if.sv | 80 ++++++++
 rtl/riscv_i32_fetch_debug_ctrl.sv | 150 +++++++++++++++
 tb/tb_riscv_i32_fetch_debug_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_i32_fetch_debug_ctrl_if.sv
// Bundle of the debug command/response, pipeline fetch request/response,
// memory fetch request/response and retire trace buses around the fetch debug sequencer.
interface riscv_i32_fetch_debug_ctrl_if;
  logic        debug_control__valid;
  logic        debug_control__kill_fetch;
  logic        debug_control__halt_request;
  logic        debug_control__fetch_dret;
  logic [31:0] debug_control__data;

  logic        pipeline_ifetch_req__valid;
  logic [31:0] pipeline_ifetch_req__address;
  logic        pipeline_ifetch_req__sequential;
  logic [2:0]  pipeline_ifetch_req__mode;
  logic        pipeline_ifetch_req__flush;

  logic        ifetch_resp__valid;
  logic        ifetch_resp__debug;
  logic [31:0] ifetch_resp__data;
  logic [2:0]  ifetch_resp__mode;
  logic        ifetch_resp__error;
  logic [1:0]  ifetch_resp__tag;

  logic        pipeline_trace__instr_valid;
  logic        pipeline_trace__rfw_data_valid;
  logic [31:0] pipeline_trace__rfw_data;
  logic        pipeline_trace__trap;

  logic        ifetch_req__valid;
  logic [31:0] ifetch_req__address;
  logic        ifetch_req__sequential;
  logic [2:0]  ifetch_req__mode;
  logic        ifetch_req__flush;

  logic        pipeline_ifetch_resp__valid;
  logic        pipeline_ifetch_resp__debug;
  logic [31:0] pipeline_ifetch_resp__data;
  logic [2:0]  pipeline_ifetch_resp__mode;
  logic        pipeline_ifetch_resp__error;
  logic [1:0]  pipeline_ifetch_resp__tag;

  logic        debug_response__valid;
  logic        debug_response__kill_fetch;
  logic        debug_response__halt_request;
  logic        debug_response__fetch_dret;
  logic [31:0] debug_response__data;

  modport slave (
    input  debug_control__valid, debug_control__kill_fetch, debug_control__halt_request,
           debug_control__fetch_dret, debug_control__data,
           pipeline_ifetch_req__valid, pipeline_ifetch_req__address, pipeline_ifetch_req__sequential,
           pipeline_ifetch_req__mode, pipeline_ifetch_req__flush,
           ifetch_resp__valid, ifetch_resp__debug, ifetch_resp__data, ifetch_resp__mode,
           ifetch_resp__error, ifetch_resp__tag,
           pipeline_trace__instr_valid, pipeline_trace__rfw_data_valid, pipeline_trace__rfw_data,
           pipeline_trace__trap,
    output ifetch_req__valid, ifetch_req__address, ifetch_req__sequential, ifetch_req__mode,
           ifetch_req__flush,
           pipeline_ifetch_resp__valid, pipeline_ifetch_resp__debug, pipeline_ifetch_resp__data,
           pipeline_ifetch_resp__mode, pipeline_ifetch_resp__error, pipeline_ifetch_resp__tag,
           debug_response__valid, debug_response__kill_fetch, debug_response__halt_request,
           debug_response__fetch_dret, debug_response__data
  );

  modport master (
    output debug_control__valid, debug_control__kill_fetch, debug_control__halt_request,
           debug_control__fetch_dret, debug_control__data,
           pipeline_ifetch_req__valid, pipeline_ifetch_req__address, pipeline_ifetch_req__sequential,
           pipeline_ifetch_req__mode, pipeline_ifetch_req__flush,
           ifetch_resp__valid, ifetch_resp__debug, ifetch_resp__data, ifetch_resp__mode,
           ifetch_resp__error, ifetch_resp__tag,
           pipeline_trace__instr_valid, pipeline_trace__rfw_data_valid, pipeline_trace__rfw_data,
           pipeline_trace__trap,
    input  ifetch_req__valid, ifetch_req__address, ifetch_req__sequential, ifetch_req__mode,
           ifetch_req__flush,
           pipeline_ifetch_resp__valid, pipeline_ifetch_resp__debug, pipeline_ifetch_resp__data,
           pipeline_ifetch_resp__mode, pipeline_ifetch_resp__error, pipeline_ifetch_resp__tag,
           debug_response__valid, debug_response__kill_fetch, debug_response__halt_request,
           debug_response__fetch_dret, debug_response__data
  );
endinterface

// File: rtl/riscv_i32_fetch_debug_ctrl.sv
// Fetch debug sequencer: drains fetch on halt, injects debug instructions, resumes on dret.
// Optional EXEC watchdog enabled by defining RISCV_I32_FETCH_DEBUG_TIMEOUT_EN.
module riscv_i32_fetch_debug_ctrl (
  input logic                          clk,
  input logic                          reset,
  riscv_i32_fetch_debug_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    DRAIN  = 3'd1,
    HALTED = 3'd2,
    ISSUE  = 3'd3,
    EXEC   = 3'd4
  } state_e;

  state_e      state_q;
  logic [1:0]  outst_q, outst_d;
  logic [31:0] inj_data_q;
  logic        rsp_valid_q, rsp_kill_q, rsp_halt_q, rsp_dret_q;
  logic [31:0] rsp_data_q;
  logic        req_valid_gated;
  logic        cmd_kill, cmd_dret, cmd_halt, cmd_inject;
`ifdef RISCV_I32_FETCH_DEBUG_TIMEOUT_EN
  logic [7:0]  tmo_q;
`endif

  // Saturating 0..3 step of the outstanding-request counter.
  function automatic logic [1:0] outst_step(logic [1:0] cnt, logic inc, logic dec);
    if (inc && !dec) return (cnt == 2'd3) ? cnt : cnt + 2'd1;
    if (dec && !inc) return (cnt == 2'd0) ? cnt : cnt - 2'd1;
    return cnt;
  endfunction

  assign cmd_kill   = bus.debug_control__valid && bus.debug_control__kill_fetch;
  assign cmd_dret   = bus.debug_control__valid && !bus.debug_control__kill_fetch &&
                      bus.debug_control__fetch_dret;
  assign cmd_halt   = bus.debug_control__valid && !bus.debug_control__kill_fetch &&
                      !bus.debug_control__fetch_dret && bus.debug_control__halt_request;
  assign cmd_inject = bus.debug_control__valid && !bus.debug_control__kill_fetch &&
                      !bus.debug_control__fetch_dret && !bus.debug_control__halt_request;

  assign req_valid_gated            = (state_q == RUN) && bus.pipeline_ifetch_req__valid;
  assign bus.ifetch_req__valid      = req_valid_gated;
  assign bus.ifetch_req__address    = bus.pipeline_ifetch_req__address;
  assign bus.ifetch_req__sequential = bus.pipeline_ifetch_req__sequential;
  assign bus.ifetch_req__mode       = bus.pipeline_ifetch_req__mode;
  assign bus.ifetch_req__flush      = bus.pipeline_ifetch_req__flush;

  assign outst_d = outst_step(outst_q, req_valid_gated, bus.ifetch_resp__valid);

  always_comb begin
    bus.pipeline_ifetch_resp__valid = 1'b0;
    bus.pipeline_ifetch_resp__debug = bus.ifetch_resp__debug;
    bus.pipeline_ifetch_resp__data  = bus.ifetch_resp__data;
    bus.pipeline_ifetch_resp__mode  = bus.ifetch_resp__mode;
    bus.pipeline_ifetch_resp__error = bus.ifetch_resp__error;
    bus.pipeline_ifetch_resp__tag   = bus.ifetch_resp__tag;
    if (state_q == RUN || state_q == DRAIN) begin
      bus.pipeline_ifetch_resp__valid = bus.ifetch_resp__valid;
    end else if (state_q == ISSUE) begin
      bus.pipeline_ifetch_resp__valid = 1'b1;
      bus.pipeline_ifetch_resp__debug = 1'b1;
      bus.pipeline_ifetch_resp__data  = inj_data_q;
      bus.pipeline_ifetch_resp__mode  = 3'b111;
      bus.pipeline_ifetch_resp__error = 1'b0;
      bus.pipeline_ifetch_resp__tag   = 2'd0;
    end
  end

  assign bus.debug_response__valid        = rsp_valid_q;
  assign bus.debug_response__kill_fetch   = rsp_kill_q;
  assign bus.debug_response__halt_request = rsp_halt_q;
  assign bus.debug_response__fetch_dret   = rsp_dret_q;
  assign bus.debug_response__data         = rsp_data_q;

  // Sequencer state, outstanding count and the single-cycle debug response pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      outst_q     <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_kill_q  <= 1'b0;
      rsp_halt_q  <= 1'b0;
      rsp_dret_q  <= 1'b0;
      rsp_data_q  <= 32'd0;
`ifdef RISCV_I32_FETCH_DEBUG_TIMEOUT_EN
      tmo_q       <= 8'd0;
`endif
    end else begin
      outst_q     <= outst_d;
      rsp_valid_q <= 1'b0;
      rsp_kill_q  <= 1'b0;
      rsp_halt_q  <= 1'b0;
      rsp_dret_q  <= 1'b0;
      rsp_data_q  <= 32'd0;
`ifdef RISCV_I32_FETCH_DEBUG_TIMEOUT_EN
      tmo_q       <= (state_q == EXEC) ? tmo_q + 8'd1 : 8'd0;
`endif
      case (state_q)
        RUN: begin
          if (cmd_halt) state_q <= DRAIN;
        end
        DRAIN: begin
          if (outst_q == 2'd0) begin
            state_q     <= HALTED;
            rsp_valid_q <= 1'b1;
            rsp_halt_q  <= 1'b1;
          end
        end
        HALTED: begin
          if (cmd_dret) begin
            state_q     <= RUN;
            rsp_valid_q <= 1'b1;
            rsp_dret_q  <= 1'b1;
          end else if (cmd_halt) begin
            rsp_valid_q <= 1'b1;
            rsp_halt_q  <= 1'b1;
          end else if (cmd_inject) begin
            inj_data_q  <= bus.debug_control__data;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= cmd_kill ? HALTED : EXEC;
        end
        EXEC: begin
          if (cmd_kill) begin
            state_q <= HALTED;
          end else if (bus.pipeline_trace__instr_valid) begin
            state_q     <= HALTED;
            rsp_valid_q <= 1'b1;
            rsp_kill_q  <= bus.pipeline_trace__trap;
            rsp_data_q  <= bus.pipeline_trace__rfw_data_valid ? bus.pipeline_trace__rfw_data : 32'd0;
          end
`ifdef RISCV_I32_FETCH_DEBUG_TIMEOUT_EN
          else if (tmo_q == 8'hFF) begin
            state_q     <= HALTED;
            rsp_valid_q <= 1'b1;
            rsp_kill_q  <= 1'b1;
            rsp_data_q  <= 32'hDEAD_0001;
          end
`endif
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_i32_fetch_debug_ctrl.sv
// Directed bench for the fetch debug sequencer: pass-through, halt/drain, inject, trap, kill, dret, reset.
module tb_riscv_i32_fetch_debug_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  riscv_i32_fetch_debug_ctrl_if bus ();

  riscv_i32_fetch_debug_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic cmd(input logic k, input logic d, input logic h, input logic [31:0] data);
    bus.debug_control__valid        = 1'b1;
    bus.debug_control__kill_fetch   = k;
    bus.debug_control__fetch_dret   = d;
    bus.debug_control__halt_request = h;
    bus.debug_control__data         = data;
  endtask

  task automatic cmd_clear();
    bus.debug_control__valid        = 1'b0;
    bus.debug_control__kill_fetch   = 1'b0;
    bus.debug_control__fetch_dret   = 1'b0;
    bus.debug_control__halt_request = 1'b0;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic k, input logic h,
                         input logic d, input logic [31:0] data);
    chk({tag, ".valid"}, {31'd0, bus.debug_response__valid}, {31'd0, v});
    chk({tag, ".kill"},  {31'd0, bus.debug_response__kill_fetch}, {31'd0, k});
    chk({tag, ".halt"},  {31'd0, bus.debug_response__halt_request}, {31'd0, h});
    chk({tag, ".dret"},  {31'd0, bus.debug_response__fetch_dret}, {31'd0, d});
    chk({tag, ".data"},  bus.debug_response__data, data);
  endtask

  initial begin
    reset = 1'b1;
    cmd_clear();
    bus.debug_control__data             = 32'd0;
    bus.pipeline_ifetch_req__valid      = 1'b0;
    bus.pipeline_ifetch_req__address    = 32'd0;
    bus.pipeline_ifetch_req__sequential = 1'b0;
    bus.pipeline_ifetch_req__mode       = 3'd0;
    bus.pipeline_ifetch_req__flush      = 1'b0;
    bus.ifetch_resp__valid              = 1'b0;
    bus.ifetch_resp__debug              = 1'b0;
    bus.ifetch_resp__data               = 32'd0;
    bus.ifetch_resp__mode               = 3'd0;
    bus.ifetch_resp__error              = 1'b0;
    bus.ifetch_resp__tag                = 2'd0;
    bus.pipeline_trace__instr_valid     = 1'b0;
    bus.pipeline_trace__rfw_data_valid  = 1'b0;
    bus.pipeline_trace__rfw_data        = 32'd0;
    bus.pipeline_trace__trap            = 1'b0;
    cyc(); cyc();
    chk_rsp("reset_rsp", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    cyc();

    // RUN pass-through
    bus.pipeline_ifetch_req__valid      = 1'b1;
    bus.pipeline_ifetch_req__address    = 32'h100;
    bus.pipeline_ifetch_req__sequential = 1'b1;
    bus.pipeline_ifetch_req__mode       = 3'd3;
    #1;
    chk("run_req_valid", {31'd0, bus.ifetch_req__valid}, 32'd1);
    chk("run_req_addr", bus.ifetch_req__address, 32'h100);
    chk("run_req_mode", {29'd0, bus.ifetch_req__mode}, 32'd3);
    cyc();
    bus.pipeline_ifetch_req__valid = 1'b0;
    bus.ifetch_resp__valid = 1'b1;
    bus.ifetch_resp__data  = 32'h0000_0013;
    bus.ifetch_resp__mode  = 3'd3;
    bus.ifetch_resp__tag   = 2'd2;
    #1;
    chk("run_resp_valid", {31'd0, bus.pipeline_ifetch_resp__valid}, 32'd1);
    chk("run_resp_data", bus.pipeline_ifetch_resp__data, 32'h13);
    chk("run_resp_tag", {30'd0, bus.pipeline_ifetch_resp__tag}, 32'd2);
    chk("run_resp_debug", {31'd0, bus.pipeline_ifetch_resp__debug}, 32'd0);
    chk("run_no_dbg_rsp", {31'd0, bus.debug_response__valid}, 32'd0);
    cyc();
    bus.ifetch_resp__valid = 1'b0;

    // Halt with two requests outstanding
    bus.pipeline_ifetch_req__valid   = 1'b1;
    bus.pipeline_ifetch_req__address = 32'h104;
    cyc();
    bus.pipeline_ifetch_req__address = 32'h108;
    cmd(1'b0, 1'b0, 1'b1, 32'd0);
    cyc();
    cmd_clear();
    #1;
    chk("drain_req_valid", {31'd0, bus.ifetch_req__valid}, 32'd0);
    chk("drain_req_addr", bus.ifetch_req__address, 32'h108);
    bus.ifetch_resp__valid = 1'b1;
    cyc();
    bus.ifetch_resp__valid = 1'b0;
    cyc();
    chk("drain_wait1", {31'd0, bus.debug_response__valid}, 32'd0);
    bus.ifetch_resp__valid = 1'b1;
    #1;
    chk("drain_resp_fwd", {31'd0, bus.pipeline_ifetch_resp__valid}, 32'd1);
    cyc();
    bus.ifetch_resp__valid = 1'b0;
    chk("drain_wait2", {31'd0, bus.debug_response__valid}, 32'd0);
    cyc();
    chk_rsp("halt_rsp", 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    bus.ifetch_resp__valid = 1'b1;
    #1;
    chk("halted_resp_blk", {31'd0, bus.pipeline_ifetch_resp__valid}, 32'd0);
    chk("halted_req_blk", {31'd0, bus.ifetch_req__valid}, 32'd0);
    bus.ifetch_resp__valid = 1'b0;
    bus.pipeline_ifetch_req__valid = 1'b0;
    cyc();
    chk("halt_pulse_end", {31'd0, bus.debug_response__valid}, 32'd0);

    // Inject addi x1,x0,1 and retire with a register write
    bus.ifetch_resp__data  = 32'hFFFF_FFFF;
    bus.ifetch_resp__error = 1'b1;
    cmd(1'b0, 1'b0, 1'b0, 32'h0010_0093);
    cyc();
    cmd_clear();
    #1;
    chk("issue_valid", {31'd0, bus.pipeline_ifetch_resp__valid}, 32'd1);
    chk("issue_debug", {31'd0, bus.pipeline_ifetch_resp__debug}, 32'd1);
    chk("issue_data", bus.pipeline_ifetch_resp__data, 32'h0010_0093);
    chk("issue_mode", {29'd0, bus.pipeline_ifetch_resp__mode}, 32'd7);
    chk("issue_error", {31'd0, bus.pipeline_ifetch_resp__error}, 32'd0);
    chk("issue_tag", {30'd0, bus.pipeline_ifetch_resp__tag}, 32'd0);
    cyc();
    chk("exec_resp_valid", {31'd0, bus.pipeline_ifetch_resp__valid}, 32'd0);
    bus.pipeline_trace__instr_valid    = 1'b1;
    bus.pipeline_trace__rfw_data_valid = 1'b1;
    bus.pipeline_trace__rfw_data       = 32'd1;
    cyc();
    bus.pipeline_trace__instr_valid    = 1'b0;
    bus.pipeline_trace__rfw_data_valid = 1'b0;
    chk_rsp("retire_rsp", 1'b1, 1'b0, 1'b0, 1'b0, 32'd1);

    // Inject, retire with a trap
    cmd(1'b0, 1'b0, 1'b0, 32'h0000_0073);
    cyc();
    cmd_clear();
    cyc();
    bus.pipeline_trace__instr_valid = 1'b1;
    bus.pipeline_trace__trap        = 1'b1;
    bus.pipeline_trace__rfw_data    = 32'h55;
    cyc();
    bus.pipeline_trace__instr_valid = 1'b0;
    bus.pipeline_trace__trap        = 1'b0;
    chk_rsp("trap_rsp", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    cmd(1'b0, 1'b0, 1'b1, 32'd0);
    cyc();
    cmd_clear();
    chk_rsp("halted_halt_rsp", 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);

    // Kill during EXEC, then a fresh injection
    cmd(1'b0, 1'b0, 1'b0, 32'h1111_1111);
    cyc();
    cmd_clear();
    cyc();
    cmd(1'b1, 1'b0, 1'b0, 32'd0);
    cyc();
    cmd_clear();
    chk("kill_no_rsp", {31'd0, bus.debug_response__valid}, 32'd0);
    cyc();
    chk("kill_no_rsp2", {31'd0, bus.debug_response__valid}, 32'd0);
    cmd(1'b0, 1'b0, 1'b0, 32'h2222_2222);
    cyc();
    cmd_clear();
    #1;
    chk("reinject_valid", {31'd0, bus.pipeline_ifetch_resp__valid}, 32'd1);
    chk("reinject_data", bus.pipeline_ifetch_resp__data, 32'h2222_2222);
    cyc();
    bus.pipeline_trace__instr_valid    = 1'b1;
    bus.pipeline_trace__rfw_data_valid = 1'b1;
    bus.pipeline_trace__rfw_data       = 32'h0000_ABCD;
    cyc();
    bus.pipeline_trace__instr_valid    = 1'b0;
    bus.pipeline_trace__rfw_data_valid = 1'b0;
    chk_rsp("reinject_rsp", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_ABCD);

    // Kill while HALTED is ignored
    cmd(1'b1, 1'b0, 1'b0, 32'd0);
    cyc();
    cmd_clear();
    chk("halted_kill_ign", {31'd0, bus.debug_response__valid}, 32'd0);
    bus.pipeline_ifetch_req__valid = 1'b1;
    #1;
    chk("halted_still_blk", {31'd0, bus.ifetch_req__valid}, 32'd0);
    bus.pipeline_ifetch_req__valid = 1'b0;

`ifdef RISCV_I32_FETCH_DEBUG_TIMEOUT_EN
    begin
      bit seen;
      seen = 1'b0;
      cmd(1'b0, 1'b0, 1'b0, 32'h0000_0013);
      cyc();
      cmd_clear();
      for (int i = 0; i < 300 && !seen; i++) begin
        cyc();
        if (bus.debug_response__valid) seen = 1'b1;
      end
      chk("timeout_seen", {31'd0, seen}, 32'd1);
      chk("timeout_data", bus.debug_response__data, 32'hDEAD_0001);
      chk("timeout_kill", {31'd0, bus.debug_response__kill_fetch}, 32'd1);
    end
`endif

    // dret (with halt also set: dret wins) resumes fetch
    cmd(1'b0, 1'b1, 1'b1, 32'd0);
    cyc();
    cmd_clear();
    chk_rsp("dret_rsp", 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    bus.pipeline_ifetch_req__valid = 1'b1;
    #1;
    chk("resume_req_valid", {31'd0, bus.ifetch_req__valid}, 32'd1);
    cyc();
    bus.pipeline_ifetch_req__valid = 1'b0;

    // Reset mid-drain: back to RUN with responses forwarded
    cmd(1'b0, 1'b0, 1'b1, 32'd0);
    cyc();
    cmd_clear();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk_rsp("midreset_rsp", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    bus.ifetch_resp__valid = 1'b1;
    bus.pipeline_ifetch_req__valid = 1'b1;
    #1;
    chk("midreset_resp_fwd", {31'd0, bus.pipeline_ifetch_resp__valid}, 32'd1);
    chk("midreset_req_pass", {31'd0, bus.ifetch_req__valid}, 32'd1);
    cyc();
    bus.ifetch_resp__valid = 1'b0;
    bus.pipeline_ifetch_req__valid = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
